// File: rtl/display_arbiter_if.sv
// Bundle between the message requesters / background source and the display arbiter.
// master = requester side, slave = arbiter side.
interface display_arbiter_if;
    logic [15:0] bg_in;
    logic [2:0]  req;
    logic [47:0] data_in;
    logic        blink_en;
    logic [15:0] disp_data;
    logic [1:0]  disp_src;
    logic        busy;
    logic [2:0]  ack;
    logic [2:0]  drop;

    modport master (
        output bg_in, req, data_in, blink_en,
        input  disp_data, disp_src, busy, ack, drop
    );

    modport slave (
        input  bg_in, req, data_in, blink_en,
        output disp_data, disp_src, busy, ack, drop
    );
endinterface

// File: rtl/display_arbiter.sv
// Shares a 4-digit BCD display between three prioritised message channels (ch0 highest)
// and a background value; each granted message is held for HOLD_CYC cycles, ch0 may blink.
module display_arbiter #(
    parameter int unsigned HOLD_CYC  = 50_000_000,
    parameter int unsigned BLINK_CYC = 12_500_000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    display_arbiter_if.slave  arb
);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [15:0]      msg_buf_q [3];
    logic [15:0]      msg_buf_d [3];
    logic [15:0]      cur_data_q, cur_data_d;
    logic [1:0]       cur_src_q, cur_src_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [2:0]       ack_q, ack_d;
    logic [2:0]       drop_q, drop_d;

    logic [1:0]       top_pend;
    logic [2:0]       le_mask;
    logic             preempt;
    logic             load;
    logic [2:0]       pend_clr;

    always_comb begin
        top_pend = 2'd0;
        casez (pend_q)
            3'b??1:  top_pend = 2'd0;
            3'b?10:  top_pend = 2'd1;
            3'b100:  top_pend = 2'd2;
            default: top_pend = 2'd0;
        endcase
    end

    // Channels at or above the current one's priority may take the display over.
    always_comb begin
        le_mask = 3'b111;
        case (cur_src_q)
            2'd0:    le_mask = 3'b001;
            2'd1:    le_mask = 3'b011;
            default: le_mask = 3'b111;
        endcase
        preempt = |(pend_q & le_mask);
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            msg_buf_d[i] = arb.req[i] ? arb.data_in[16*i +: 16] : msg_buf_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_data_d = cur_data_q;
        cur_src_d  = cur_src_q;
        hold_d     = hold_q;
        ack_d      = '0;
        drop_d     = '0;
        pend_clr   = '0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    load    = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (preempt) begin
                    load = 1'b1;
                    if (top_pend < cur_src_q) begin
                        drop_d[cur_src_q] = 1'b1;
                    end
                end else if (hold_q == '0) begin
                    if (|pend_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cur_src_d          = top_pend;
            cur_data_d         = msg_buf_q[top_pend];
            hold_d             = HOLD_LOAD;
            pend_clr[top_pend] = 1'b1;
            ack_d[top_pend]    = 1'b1;
        end

        // A request landing on its own load edge keeps pend set, so it reloads next edge.
        pend_d = (pend_q & ~pend_clr) | arb.req;
    end

    always_comb begin
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        if (load) begin
            phase_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (state_q == SHOW && cur_src_q == 2'd0) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                msg_buf_q[i] <= '0;
            end
            cur_data_q  <= '0;
            cur_src_q   <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            ack_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            for (int unsigned i = 0; i < 3; i++) begin
                msg_buf_q[i] <= msg_buf_d[i];
            end
            cur_data_q  <= cur_data_d;
            cur_src_q   <= cur_src_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            ack_q       <= ack_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        arb.disp_data = arb.bg_in;
        arb.disp_src  = 2'd3;
        arb.busy      = (state_q == SHOW);
        arb.ack       = ack_q;
        arb.drop      = drop_q;
        if (state_q == SHOW) begin
            arb.disp_src = cur_src_q;
            if (!(cur_src_q == 2'd0 && arb.blink_en && phase_q)) begin
                arb.disp_data = cur_data_q;
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: per-cycle expectations are queued as stimulus is
// driven and popped/compared one cycle-sample at a time.
module tb_display_arbiter;

    localparam logic [15:0] BG = 16'h1234;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_arbiter_if arb ();

    display_arbiter #(
        .HOLD_CYC (8),
        .BLINK_CYC(2),
        .CNT_W    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arb  (arb)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
        logic        b;
        logic [2:0]  a;
        logic [2:0]  dr;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tag    = "init";
    logic [15:0] bg = BG;

    task automatic push(input logic [15:0] d, input logic [1:0] s, input logic b,
                        input logic [2:0] a, input logic [2:0] dr);
        exp_t e;
        e.d = d; e.s = s; e.b = b; e.a = a; e.dr = dr;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got nothing required an entry", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (arb.disp_data === e.d) else begin
            errors++;
            $error("FAIL %s disp_data got %h required %h", tag, arb.disp_data, e.d);
        end
        checks++;
        assert (arb.disp_src === e.s) else begin
            errors++;
            $error("FAIL %s disp_src got %0d required %0d", tag, arb.disp_src, e.s);
        end
        checks++;
        assert (arb.busy === e.b) else begin
            errors++;
            $error("FAIL %s busy got %b required %b", tag, arb.busy, e.b);
        end
        checks++;
        assert (arb.ack === e.a) else begin
            errors++;
            $error("FAIL %s ack got %b required %b", tag, arb.ack, e.a);
        end
        checks++;
        assert (arb.drop === e.dr) else begin
            errors++;
            $error("FAIL %s drop got %b required %b", tag, arb.drop, e.dr);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push(bg, 2'd3, 1'b0, 3'b000, 3'b000);
            cyc();
        end
    endtask

    task automatic show(input logic [15:0] d, input logic [1:0] s, input int n,
                        input logic [2:0] a, input logic [2:0] dr);
        for (int i = 0; i < n; i++) begin
            push(d, s, 1'b1, (i == 0) ? a : 3'b000, (i == 0) ? dr : 3'b000);
            cyc();
        end
    endtask

    task automatic set_req(input int ch, input logic [15:0] d);
        arb.req                 = '0;
        arb.req[ch]             = 1'b1;
        arb.data_in[16*ch +: 16] = d;
    endtask

    logic [15:0] blink_pat [8];

    initial begin
        blink_pat = '{16'h0088, 16'h0088, 16'h1234, 16'h1234,
                      16'h0088, 16'h0088, 16'h1234, 16'h1234};
        arb.bg_in    = BG;
        arb.req      = '0;
        arb.data_in  = '0;
        arb.blink_en = 1'b0;

        // reset held, then idle
        tag = "reset";
        #1;
        push(bg, 2'd3, 1'b0, 3'b000, 3'b000);
        check_front();
        idle(2);
        rst_n = 1'b1;
        tag = "idle";
        idle(3);

        // single ch1 request
        tag = "single";
        set_req(1, 16'h0042);
        idle(1);
        arb.req = '0;
        show(16'h0042, 2'd1, 8, 3'b010, 3'b000);
        idle(2);

        // ch2 preempted by ch0
        tag = "preempt";
        set_req(2, 16'h0007);
        idle(1);
        arb.req = '0;
        show(16'h0007, 2'd2, 3, 3'b100, 3'b000);
        set_req(0, 16'h0099);
        show(16'h0007, 2'd2, 1, 3'b000, 3'b000);
        arb.req = '0;
        show(16'h0099, 2'd0, 8, 3'b001, 3'b100);
        idle(2);

        // lower priority waits for ch0 to expire
        tag = "queued";
        set_req(0, 16'h0011);
        idle(1);
        arb.req = '0;
        show(16'h0011, 2'd0, 3, 3'b001, 3'b000);
        set_req(2, 16'h0005);
        show(16'h0011, 2'd0, 1, 3'b000, 3'b000);
        arb.req = '0;
        show(16'h0011, 2'd0, 4, 3'b000, 3'b000);
        show(16'h0005, 2'd2, 8, 3'b100, 3'b000);
        idle(2);

        // same-channel reload restarts hold
        tag = "reload";
        set_req(1, 16'h0033);
        idle(1);
        arb.req = '0;
        show(16'h0033, 2'd1, 4, 3'b010, 3'b000);
        set_req(1, 16'h0077);
        show(16'h0033, 2'd1, 1, 3'b000, 3'b000);
        arb.req = '0;
        show(16'h0077, 2'd1, 8, 3'b010, 3'b000);
        idle(1);

        // request on its own load edge
        tag = "collision";
        set_req(1, 16'h0044);
        idle(1);
        arb.data_in[31:16] = 16'h0055;
        show(16'h0044, 2'd1, 1, 3'b010, 3'b000);
        arb.req = '0;
        show(16'h0055, 2'd1, 8, 3'b010, 3'b000);
        idle(1);

        // ch0 blink
        tag = "blink";
        arb.blink_en = 1'b1;
        set_req(0, 16'h0088);
        idle(1);
        arb.req = '0;
        for (int i = 0; i < 8; i++) begin
            push(blink_pat[i], 2'd0, 1'b1, (i == 0) ? 3'b001 : 3'b000, 3'b000);
            cyc();
        end
        idle(2);
        arb.blink_en = 1'b0;

        // background passes straight through
        tag = "bg_pass";
        bg = 16'h5678;
        arb.bg_in = bg;
        #1;
        push(bg, 2'd3, 1'b0, 3'b000, 3'b000);
        check_front();
        bg = BG;
        arb.bg_in = bg;
        idle(1);

        // async reset mid-show
        tag = "reset_mid";
        set_req(1, 16'h00AB);
        idle(1);
        arb.req = '0;
        show(16'h00AB, 2'd1, 2, 3'b010, 3'b000);
        rst_n = 1'b0;
        #1;
        push(bg, 2'd3, 1'b0, 3'b000, 3'b000);
        check_front();
        #3;
        rst_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
